// File: rtl/bitslam_pkg.sv
// Shared constants for the bitslam noise mixer: register map, bus field slices, LFSR seed.
package bitslam_pkg;

  localparam logic [2:0] REG_DIV  = 3'd0;
  localparam logic [2:0] REG_TAPS = 3'd1;
  localparam logic [2:0] REG_VOL  = 3'd2;
  localparam logic [2:0] REG_MODE = 3'd3;

  localparam int VOICE_MSB = 5;
  localparam int VOICE_LSB = 3;
  localparam int REG_MSB   = 2;
  localparam int REG_LSB   = 0;

  localparam int LFSR_RESET = 1;

endpackage

// File: rtl/bitslam_voice.sv
// One bitslam voice: config registers, clock divider and LFSR (square mode with BITSLAM_SQUARE_MODE_EN).
module bitslam_voice
  import bitslam_pkg::*;
#(
  parameter int LFSR_WIDTH = 8,
  parameter int DIV_WIDTH  = 6,
  parameter int VOL_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [2:0]           wr_reg,
  input  logic [5:0]           wr_data,
  output logic                 lfsr_bit,
  output logic [VOL_WIDTH-1:0] volume
);

  logic [DIV_WIDTH-1:0]  div_max;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [5:0]            tap_mask;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] lfsr_noise;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic                  tick;
  logic                  fb;

  // >= rather than == so lowering div_max below div_cnt ticks at once instead of wrapping
  assign tick = (div_cnt >= div_max);

  always_comb begin
    fb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fb = fb ^ (tap_mask[i] & lfsr[LFSR_WIDTH-6+i]);
    end
  end

  assign lfsr_noise = (lfsr == '0) ? LFSR_WIDTH'(LFSR_RESET)
                                   : {lfsr[LFSR_WIDTH-2:0], fb};

`ifdef BITSLAM_SQUARE_MODE_EN
  logic mode;

  always_comb begin
    lfsr_next = lfsr_noise;
    if (mode) begin
      lfsr_next = {lfsr[LFSR_WIDTH-1:1], ~lfsr[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
    end else if (wr_en && (wr_reg == REG_MODE)) begin
      mode <= wr_data[0];
    end
  end
`else
  assign lfsr_next = lfsr_noise;
`endif

  // Tick and register write may coincide; the tick path sees the old register values
  always_ff @(posedge clk) begin
    if (rst) begin
      div_max  <= '0;
      div_cnt  <= '0;
      tap_mask <= '0;
      volume   <= '0;
      lfsr     <= LFSR_WIDTH'(LFSR_RESET);
    end else begin
      if (tick) begin
        div_cnt <= '0;
        lfsr    <= lfsr_next;
      end else begin
        div_cnt <= div_cnt + DIV_WIDTH'(1);
      end
      if (wr_en) begin
        case (wr_reg)
          REG_DIV:  div_max  <= wr_data[DIV_WIDTH-1:0];
          REG_TAPS: tap_mask <= wr_data;
          REG_VOL:  volume   <= wr_data[VOL_WIDTH-1:0];
          default:  ;
        endcase
      end
    end
  end

  assign lfsr_bit = lfsr[0];

endmodule

// File: rtl/bitslam_mixer.sv
// Multi-voice LFSR noise mixer: address latch, per-voice write decode, registered sum of voices.
// Optional square-wave voice mode is compiled in with BITSLAM_SQUARE_MODE_EN.
module bitslam_mixer
  import bitslam_pkg::*;
#(
  parameter int NUM_VOICES = 2,
  parameter int LFSR_WIDTH = 8,
  parameter int DIV_WIDTH  = 6,
  parameter int VOL_WIDTH  = 3,
  parameter int OUT_WIDTH  = VOL_WIDTH + $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_data_sel,
  input  logic [5:0]            addr_data,
  output logic [OUT_WIDTH-1:0]  audio_out,
  output logic [NUM_VOICES-1:0] voice_bits
);

  logic [5:0]           addr;
  logic [VOL_WIDTH-1:0] vol_v [NUM_VOICES];
  logic [OUT_WIDTH-1:0] mix_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (!addr_data_sel) begin
      addr <= addr_data;
    end
  end

  // Voice indices at or above NUM_VOICES match no instance, so those writes vanish
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    logic wr_en;

    assign wr_en = addr_data_sel && (addr[VOICE_MSB:VOICE_LSB] == 3'(i));

    bitslam_voice #(
      .LFSR_WIDTH (LFSR_WIDTH),
      .DIV_WIDTH  (DIV_WIDTH),
      .VOL_WIDTH  (VOL_WIDTH)
    ) u_voice (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_reg   (addr[REG_MSB:REG_LSB]),
      .wr_data  (addr_data),
      .lfsr_bit (voice_bits[i]),
      .volume   (vol_v[i])
    );
  end

  always_comb begin
    mix_p0 = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_bits[i]) begin
        mix_p0 = mix_p0 + OUT_WIDTH'(vol_v[i]);
      end
    end
  end

  // Stage p0 -> output: one-cycle registered mix
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_out <= '0;
    end else begin
      audio_out <= mix_p0;
    end
  end

endmodule

// File: tb/tb_bitslam_mixer.sv
// Bench for bitslam_mixer: hand-computed vector table plus randomized run against a behavioural model.
module tb_bitslam_mixer;

  localparam int NV = 2;
  localparam int LW = 8;
  localparam int DW = 6;
  localparam int VW = 3;
  localparam int OW = VW + $clog2(NV + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          addr_data_sel;
  logic [5:0]    addr_data;
  logic [OW-1:0] audio_out;
  logic [NV-1:0] voice_bits;

  int vectors     = 0;
  int miscompares = 0;

  int m_addr;
  int m_audio;
  int m_dmax [NV];
  int m_cnt  [NV];
  int m_taps [NV];
  int m_vol  [NV];
  int m_mode [NV];
  int m_lfsr [NV];

  typedef struct {
    logic       r;
    logic       s;
    logic [5:0] d;
    int         exp_audio;
    int         exp_bits;
  } vec_t;

  vec_t tbl[$];

  bitslam_mixer #(
    .NUM_VOICES (NV),
    .LFSR_WIDTH (LW),
    .DIV_WIDTH  (DW),
    .VOL_WIDTH  (VW),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_data_sel (addr_data_sel),
    .addr_data     (addr_data),
    .audio_out     (audio_out),
    .voice_bits    (voice_bits)
  );

  always #5 clk = ~clk;

  function automatic int model_bits();
    int b;
    b = 0;
    for (int v = 0; v < NV; v++) b = b | ((m_lfsr[v] & 1) << v);
    return b;
  endfunction

  // Advance the reference one clock edge from the spec's rules
  task automatic model_edge(input logic r, input logic s, input logic [5:0] d);
    int mix;
    int vi;
    int rg;
    int fb;
    if (r) begin
      m_addr  = 0;
      m_audio = 0;
      for (int v = 0; v < NV; v++) begin
        m_dmax[v] = 0; m_cnt[v] = 0; m_taps[v] = 0;
        m_vol[v]  = 0; m_mode[v] = 0; m_lfsr[v] = 1;
      end
    end else begin
      mix = 0;
      for (int v = 0; v < NV; v++) if ((m_lfsr[v] & 1) != 0) mix += m_vol[v];
      m_audio = mix;
      for (int v = 0; v < NV; v++) begin
        if (m_cnt[v] >= m_dmax[v]) begin
          m_cnt[v] = 0;
          if (m_mode[v] != 0) begin
            m_lfsr[v] = m_lfsr[v] ^ 1;
          end else if (m_lfsr[v] == 0) begin
            m_lfsr[v] = 1;
          end else begin
            fb = $countones(m_taps[v] & ((m_lfsr[v] >> (LW - 6)) & 63)) & 1;
            m_lfsr[v] = ((m_lfsr[v] << 1) | fb) & ((1 << LW) - 1);
          end
        end else begin
          m_cnt[v] = m_cnt[v] + 1;
        end
      end
      if (!s) begin
        m_addr = int'(d);
      end else begin
        vi = m_addr >> 3;
        rg = m_addr & 7;
        if (vi < NV) begin
          case (rg)
            0: m_dmax[vi] = int'(d) & ((1 << DW) - 1);
            1: m_taps[vi] = int'(d);
            2: m_vol[vi]  = int'(d) & ((1 << VW) - 1);
`ifdef BITSLAM_SQUARE_MODE_EN
            3: m_mode[vi] = int'(d) & 1;
`endif
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [5:0] d);
    rst           = r;
    addr_data_sel = s;
    addr_data     = d;
    model_edge(r, s, d);
    @(posedge clk);
    #1;
    check("model_audio", int'(audio_out), m_audio);
    check("model_bits", int'(voice_bits), model_bits());
  endtask

  task automatic add(input logic r, input logic s, input logic [5:0] d, input int a, input int b);
    vec_t t;
    t.r = r; t.s = s; t.d = d; t.exp_audio = a; t.exp_bits = b;
    tbl.push_back(t);
  endtask

  initial begin
    logic       s;
    logic [5:0] d;
    int         prev_bit;

    rst = 1'b1;
    addr_data_sel = 1'b0;
    addr_data = 6'h00;

    // Reset, volume setup, zero-lockup reload, mix 12/7, ignored writes, burst write
    add(1, 0, 6'h00, 0, 3);
    add(0, 0, 6'h00, 0, 0);
    add(0, 0, 6'h02, 0, 0);
    add(0, 1, 6'h07, 0, 0);
    add(0, 0, 6'h0A, 0, 0);
    add(0, 1, 6'h05, 0, 0);
    add(0, 0, 6'h00, 0, 0);
    add(0, 0, 6'h07, 0, 0);
    add(0, 0, 6'h00, 0, 0);
    add(0, 1, 6'h3F, 0, 3);
    add(0, 0, 6'h08, 12, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 6'h08, 7, 1);
    add(0, 1, 6'h3F, 7, 3);
    add(0, 0, 6'h38, 12, 3);
    add(0, 1, 6'h3F, 12, 3);
    add(0, 0, 6'h05, 12, 3);
    add(0, 1, 6'h00, 12, 3);
    add(0, 0, 6'h02, 12, 3);
    add(0, 1, 6'h01, 12, 3);
    add(0, 1, 6'h02, 6, 3);
    add(0, 1, 6'h03, 7, 3);
    add(0, 0, 6'h07, 8, 3);

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].d);
      check($sformatf("tbl%0d_audio", i), int'(audio_out), tbl[i].exp_audio);
      check($sformatf("tbl%0d_bits", i), int'(voice_bits), tbl[i].exp_bits);
    end

    // Idle after reset with zero volumes
    step(1, 0, 6'h00);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 6'h07);
      check("idle_zero", int'(audio_out), 0);
    end

    // Voice 0 divide-by-4 with taps 7,6,5, over 256+ ticks
    step(1, 0, 6'h00);
    step(0, 0, 6'h00);
    step(0, 1, 6'd3);
    step(0, 0, 6'h01);
    step(0, 1, 6'h38);
    step(0, 0, 6'h02);
    step(0, 1, 6'h07);
    step(0, 0, 6'h07);
    for (int i = 0; i < 1040; i++) step(0, 0, 6'h07);

    // Mode register write: square toggle with the feature, ignored noise otherwise
    step(1, 0, 6'h00);
    step(0, 0, 6'h00);
    step(0, 1, 6'd1);
    step(0, 0, 6'h03);
    step(0, 1, 6'd1);
    step(0, 0, 6'h07);
    prev_bit = int'(voice_bits[0]);
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 6'h07);
      step(0, 0, 6'h07);
`ifdef BITSLAM_SQUARE_MODE_EN
      check("square_toggle", int'(voice_bits[0]), prev_bit ^ 1);
`endif
      prev_bit = int'(voice_bits[0]);
    end

    // Randomized bus traffic with occasional reset
    step(1, 0, 6'h00);
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom_range(0, 2) == 0);
      if (!s) begin
        if ($urandom_range(0, 3) == 0) d = 6'($urandom);
        else d = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 3))};
      end else begin
        d = 6'($urandom);
        if ($urandom_range(0, 1) == 0) d = d & 6'h03;
      end
      step(($urandom_range(0, 499) == 0), s, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
